// File: rtl/psd_mixer_acc_if.sv
// Result stream of psd_mixer_acc: one I/Q word per channel with valid/ready.
// master = producer (psd_mixer_acc), slave = consumer (readout/host side).
interface psd_mixer_acc_if #(
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned CH_W      = 2
);
    logic signed [OUT_WIDTH-1:0] o_i;
    logic signed [OUT_WIDTH-1:0] o_q;
    logic        [CH_W-1:0]      o_ch;
    logic                        o_valid;
    logic                        i_ready;

    modport master (
        output o_i,
        output o_q,
        output o_ch,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_i,
        input  o_q,
        input  o_ch,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/psd_mixer_acc.sv
// Multi-channel phase-sensitive demodulator: per-channel sin/cos mixing,
// accumulate-and-dump over DECIM samples, serial I/Q emission per channel.
// Optional macro PSD_MIXER_ACC_ROUND_EN: round-half-up output scaling with
// positive saturation (only meaningful when the accumulator is wider than
// the output); default build truncates with an arithmetic shift.
module psd_mixer_acc #(
    parameter int unsigned NCH               = 4,
    parameter int unsigned DATA_WIDTH        = 1,
    parameter int unsigned SIN_WIDTH         = 8,
    parameter bit          ONEBIT_TO_BIPOLAR = 1'b1,
    parameter int unsigned DECIM             = 256,
    parameter int unsigned OUT_WIDTH         = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [NCH*DATA_WIDTH-1:0]     i_data,
    input  logic signed [SIN_WIDTH-1:0]   i_sin,
    input  logic signed [SIN_WIDTH-1:0]   i_cos,
    output logic                          o_busy,
    output logic                          o_ovf,
    psd_mixer_acc_if.master               out_if
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW    = DATA_WIDTH + SIN_WIDTH;
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned AW    = PW + CNT_W;
    localparam int          SH    = int'(AW) - int'(OUT_WIDTH);
    localparam int unsigned SHP   = (SH > 0) ? SH : 0;
    localparam int unsigned XW    = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
    localparam bit          BIP   = (DATA_WIDTH == 1) && ONEBIT_TO_BIPOLAR;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);

`ifdef PSD_MIXER_ACC_ROUND_EN
    localparam int unsigned          RND_SH  = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [XW-1:0] RND     = (SH > 0) ? (XW'(1) << RND_SH) : XW'(0);
    localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OUT_WIDTH - 1)) - 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Accumulator-to-output scaling; the extra headroom bit keeps the rounding add exact.
    function automatic logic signed [OUT_WIDTH-1:0] scale(input logic signed [AW-1:0] a);
        logic signed [XW-1:0] ext;
        logic signed [XW-1:0] shd;
        ext = XW'(a);
`ifdef PSD_MIXER_ACC_ROUND_EN
        shd = (ext + RND) >>> SHP;
        if ((SH > 0) && (shd > SAT_MAX)) begin
            shd = SAT_MAX;
        end
`else
        shd = ext >>> SHP;
`endif
        return OUT_WIDTH'(shd);
    endfunction

    logic signed [PW-1:0]        prod_i_c [NCH];
    logic signed [PW-1:0]        prod_q_c [NCH];
    logic signed [AW-1:0]        sum_i_c  [NCH];
    logic signed [AW-1:0]        sum_q_c  [NCH];

    logic signed [AW-1:0]        acc_i_q  [NCH];
    logic signed [AW-1:0]        acc_q_q  [NCH];
    logic signed [AW-1:0]        bank_i_q [NCH];
    logic signed [AW-1:0]        bank_q_q [NCH];
    logic [CNT_W-1:0]            cnt_q;

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [CH_W-1:0]             ch_nxt_c;
    logic signed [OUT_WIDTH-1:0] o_i_q, o_i_d;
    logic signed [OUT_WIDTH-1:0] o_q_q, o_q_d;
    logic                        o_valid_q, o_valid_d;
    logic                        o_busy_q, o_busy_d;
    logic                        o_ovf_q, o_ovf_d;
    logic                        dump_c;
    logic                        load_c;
    logic                        final_hs_c;

    assign dump_c   = i_en && (cnt_q == LAST_CNT);
    assign ch_nxt_c = ch_q + CH_W'(1);

    // Per-channel mix against the shared reference and the running frame sum.
    always_comb begin
        for (int k = 0; k < int'(NCH); k++) begin
            if (BIP) begin
                prod_i_c[k] = i_data[k*DATA_WIDTH] ? PW'(i_sin) : -PW'(i_sin);
                prod_q_c[k] = i_data[k*DATA_WIDTH] ? PW'(i_cos) : -PW'(i_cos);
            end else begin
                prod_i_c[k] = PW'($signed(i_data[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(i_sin);
                prod_q_c[k] = PW'($signed(i_data[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(i_cos);
            end
            sum_i_c[k] = acc_i_q[k] + AW'(prod_i_c[k]);
            sum_q_c[k] = acc_q_q[k] + AW'(prod_q_c[k]);
        end
    end

    // Accumulate-and-dump datapath; the bank only takes a frame the emitter can accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                acc_i_q[k]  <= '0;
                acc_q_q[k]  <= '0;
                bank_i_q[k] <= '0;
                bank_q_q[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (dump_c) begin
                    acc_i_q[k] <= '0;
                    acc_q_q[k] <= '0;
                end else begin
                    acc_i_q[k] <= sum_i_c[k];
                    acc_q_q[k] <= sum_q_c[k];
                end
                if (load_c) begin
                    bank_i_q[k] <= sum_i_c[k];
                    bank_q_q[k] <= sum_q_c[k];
                end
            end
            cnt_q <= dump_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Emitter state and registered output word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            o_i_q     <= '0;
            o_q_q     <= '0;
            o_valid_q <= 1'b0;
            o_busy_q  <= 1'b0;
            o_ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            o_i_q     <= o_i_d;
            o_q_q     <= o_q_d;
            o_valid_q <= o_valid_d;
            o_busy_q  <= o_busy_d;
            o_ovf_q   <= o_ovf_d;
        end
    end

    // Emitter next state: walk channels on handshake, reload on dump, flag overrun.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        o_i_d      = o_i_q;
        o_q_d      = o_q_q;
        o_valid_d  = o_valid_q;
        o_ovf_d    = o_ovf_q;
        load_c     = 1'b0;
        final_hs_c = (state_q == ST_EMIT) && out_if.i_ready && (ch_q == LAST_CH);

        case (state_q)
            ST_IDLE: begin
                if (dump_c) begin
                    load_c    = 1'b1;
                    state_d   = ST_EMIT;
                    ch_d      = '0;
                    o_valid_d = 1'b1;
                    o_i_d     = scale(sum_i_c[0]);
                    o_q_d     = scale(sum_q_c[0]);
                end
            end
            ST_EMIT: begin
                if (final_hs_c) begin
                    if (dump_c) begin
                        load_c = 1'b1;
                        ch_d   = '0;
                        o_i_d  = scale(sum_i_c[0]);
                        o_q_d  = scale(sum_q_c[0]);
                    end else begin
                        state_d   = ST_IDLE;
                        o_valid_d = 1'b0;
                    end
                end else begin
                    if (out_if.i_ready) begin
                        ch_d  = ch_nxt_c;
                        o_i_d = scale(bank_i_q[ch_nxt_c]);
                        o_q_d = scale(bank_q_q[ch_nxt_c]);
                    end
                    if (dump_c) begin
                        o_ovf_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                o_valid_d = 1'b0;
            end
        endcase

        o_busy_d = (state_d == ST_EMIT);
    end

    assign out_if.o_i     = o_i_q;
    assign out_if.o_q     = o_q_q;
    assign out_if.o_ch    = ch_q;
    assign out_if.o_valid = o_valid_q;
    assign o_busy         = o_busy_q;
    assign o_ovf          = o_ovf_q;

endmodule

// File: tb/tb_psd_mixer_acc.sv
// Directed bench for psd_mixer_acc: NCH=2, 1-bit bipolar data, SIN_WIDTH=8,
// DECIM=4. dut_a uses OUT_WIDTH=11 (no shift), dut_b OUT_WIDTH=8 (shift by 3);
// both see identical stimulus.
module tb_psd_mixer_acc;

    logic              clk;
    logic              rst;
    logic              en;
    logic [1:0]        data;
    logic signed [7:0] sin;
    logic signed [7:0] cos;
    logic              ready;
    logic              busy_a, ovf_a, busy_b, ovf_b;

    int n_checks;
    int n_fail;
    int n_words;

    psd_mixer_acc_if #(.OUT_WIDTH(11), .CH_W(1)) bus_a ();
    psd_mixer_acc_if #(.OUT_WIDTH(8),  .CH_W(1)) bus_b ();

    assign bus_a.i_ready = ready;
    assign bus_b.i_ready = ready;

    psd_mixer_acc #(
        .NCH(2), .DATA_WIDTH(1), .SIN_WIDTH(8), .ONEBIT_TO_BIPOLAR(1'b1),
        .DECIM(4), .OUT_WIDTH(11)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_sin(sin), .i_cos(cos), .o_busy(busy_a), .o_ovf(ovf_a),
        .out_if(bus_a)
    );

    psd_mixer_acc #(
        .NCH(2), .DATA_WIDTH(1), .SIN_WIDTH(8), .ONEBIT_TO_BIPOLAR(1'b1),
        .DECIM(4), .OUT_WIDTH(8)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_sin(sin), .i_cos(cos), .o_busy(busy_b), .o_ovf(ovf_b),
        .out_if(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four enabled samples with constant stimulus; returns in the window after the dump edge.
    task automatic run_frame(input logic [1:0] d, input int s, input int c);
        data = d;
        sin  = 8'(s);
        cos  = 8'(c);
        en   = 1'b1;
        repeat (4) tick();
        en   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        data  = '0;
        sin   = '0;
        cos   = '0;
        ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", bus_a.o_valid, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_ovf",   ovf_a, 0);
        check("rst_i",     bus_a.o_i, 0);
        check("rst_ch",    bus_a.o_ch, 0);
        rst = 1'b0;

        // T1: basic frame, consumer always ready
        ready = 1'b1;
        run_frame(2'b01, 100, -50);
        check("t1_valid0", bus_a.o_valid, 1);
        check("t1_busy0",  busy_a, 1);
        check("t1_ch0",    bus_a.o_ch, 0);
        check("t1_i0",     bus_a.o_i, 400);
        check("t1_q0",     bus_a.o_q, -200);
        tick();
        check("t1_valid1", bus_a.o_valid, 1);
        check("t1_ch1",    bus_a.o_ch, 1);
        check("t1_i1",     bus_a.o_i, -400);
        check("t1_q1",     bus_a.o_q, 200);
        tick();
        check("t1_valid_end", bus_a.o_valid, 0);
        check("t1_busy_end",  busy_a, 0);

        // T2: back-pressure holds the ch0 word
        ready = 1'b0;
        run_frame(2'b01, 100, -50);
        check("t2_ch0_first", bus_a.o_i, 400);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", bus_a.o_valid, 1);
            check("t2_hold_ch",    bus_a.o_ch, 0);
            check("t2_hold_i",     bus_a.o_i, 400);
        end
        ready = 1'b1;
        tick();
        check("t2_ch1",  bus_a.o_ch, 1);
        check("t2_i1",   bus_a.o_i, -400);
        tick();
        check("t2_valid_end", bus_a.o_valid, 0);

        // T3: second dump while stalled -> overrun, first frame intact
        ready = 1'b0;
        run_frame(2'b01, 100, -50);
        check("t3_ovf_first", ovf_a, 0);
        run_frame(2'b10, 20, 30);
        check("t3_ovf",   ovf_a, 1);
        check("t3_ch0",   bus_a.o_ch, 0);
        check("t3_i0",    bus_a.o_i, 400);
        check("t3_q0",    bus_a.o_q, -200);
        ready = 1'b1;
        tick();
        check("t3_ch1",   bus_a.o_ch, 1);
        check("t3_i1",    bus_a.o_i, -400);
        check("t3_q1",    bus_a.o_q, 200);
        tick();
        check("t3_valid_end", bus_a.o_valid, 0);
        check("t3_ovf_sticky", ovf_a, 1);

        // T4: reset mid-frame discards partial sums and clears overrun
        data = 2'b01;
        sin  = 8'sd100;
        cos  = -8'sd50;
        en   = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        check("t4_ovf_rst",   ovf_a, 0);
        check("t4_valid_rst", bus_a.o_valid, 0);
        run_frame(2'b01, 10, 0);
        check("t4_i0",  bus_a.o_i, 40);
        check("t4_q0",  bus_a.o_q, 0);
        check("t4_ovf", ovf_a, 0);
        tick();
        check("t4_i1",  bus_a.o_i, -40);
        tick();

        // T5: narrow output scaling (acc +12 / -12, shift 3)
        run_frame(2'b01, 3, 0);
        check("t5_a_i0", bus_a.o_i, 12);
`ifdef PSD_MIXER_ACC_ROUND_EN
        check("t5_b_i0", bus_b.o_i, 2);
`else
        check("t5_b_i0", bus_b.o_i, 1);
`endif
        tick();
        check("t5_a_i1", bus_a.o_i, -12);
`ifdef PSD_MIXER_ACC_ROUND_EN
        check("t5_b_i1", bus_b.o_i, -1);
`else
        check("t5_b_i1", bus_b.o_i, -2);
`endif
        tick();

        // T6: continuous streaming, three frames
        data    = 2'b01;
        sin     = 8'sd100;
        cos     = -8'sd50;
        ready   = 1'b1;
        n_words = 0;
        for (int i = 0; i < 16; i++) begin
            en = (i < 12);
            tick();
            if (bus_a.o_valid) begin
                check("t6_ch", bus_a.o_ch, n_words % 2);
                check("t6_i",  bus_a.o_i, (n_words % 2 == 0) ? 400 : -400);
                n_words++;
            end
        end
        en = 1'b0;
        check("t6_words", n_words, 6);
        check("t6_ovf",   ovf_a, 0);

        // T7: dump on the final handshake cycle reloads without overrun
        data  = 2'b01;
        sin   = 8'sd100;
        cos   = -8'sd50;
        ready = 1'b0;
        en    = 1'b1;
        repeat (4) tick();
        check("t7_f1_i0", bus_a.o_i, 400);
        data = 2'b10;
        sin  = 8'sd20;
        cos  = 8'sd30;
        tick();
        tick();
        ready = 1'b1;
        tick();
        check("t7_f1_ch1", bus_a.o_ch, 1);
        check("t7_f1_i1",  bus_a.o_i, -400);
        tick();
        en = 1'b0;
        check("t7_valid", bus_a.o_valid, 1);
        check("t7_ch0",   bus_a.o_ch, 0);
        check("t7_f2_i0", bus_a.o_i, -80);
        check("t7_f2_q0", bus_a.o_q, -120);
        check("t7_ovf",   ovf_a, 0);
        tick();
        check("t7_f2_i1", bus_a.o_i, 80);
        check("t7_f2_q1", bus_a.o_q, 120);
        tick();
        check("t7_valid_end", bus_a.o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
